// File: rtl/logic_ops_pkg.sv
// Shared encodings for the chunked logic unit:
// operation codes and FSM states.
package logic_ops_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NOR   = 3'd2,
        OP_XOR   = 3'd3,
        OP_NAND  = 3'd4,
        OP_XNOR  = 3'd5,
        OP_ANDN  = 3'd6,
        OP_PASSA = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/logic_slice.sv
// Combinational bitwise operator applied to
// one CHUNK-wide slice of the operands.
module logic_slice
    import logic_ops_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  op_e              op,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic [CHUNK-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_NOR:   y = ~(a | b);
            OP_XOR:   y = a ^ b;
            OP_NAND:  y = ~(a & b);
            OP_XNOR:  y = ~(a ^ b);
            OP_ANDN:  y = a & ~b;
            OP_PASSA: y = a;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: evaluates CHUNK
// bits per cycle, LSB chunk first, with handshakes.
module seq_logic_unit
    import logic_ops_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             zero,
    output logic             ones,
    output logic             busy
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("seq_logic_unit: WIDTH must be a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             zero_q, zero_d;
    logic             ones_q, ones_d;

    int unsigned      base;
    logic [CHUNK-1:0] y;

    assign base = 32'(idx_q) * CHUNK;

    logic_slice #(.CHUNK(CHUNK)) u_slice (
        .op (op_q),
        .a  (a_q[base +: CHUNK]),
        .b  (b_q[base +: CHUNK]),
        .y  (y)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        s_d     = s_q;
        zero_d  = zero_q;
        ones_d  = ones_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op_e'(op);
                    s_d     = '0;
                    zero_d  = 1'b0;
                    ones_d  = 1'b0;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_d[base +: CHUNK] = y;
                // idx parks on the last chunk; accept clears it
                if (idx_q == LAST) begin
                    zero_d  = (s_d == '0);
                    ones_d  = &s_d;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_AND;
            s_q     <= '0;
            zero_q  <= 1'b0;
            ones_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            s_q     <= s_d;
            zero_q  <= zero_d;
            ones_q  <= ones_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign s         = s_q;
    assign zero      = zero_q;
    assign ones      = ones_q;

endmodule

// File: tb/tb_seq_logic_unit.sv
// Directed + random bench for seq_logic_unit
// against a full-width behavioural model.
module tb_seq_logic_unit;

    localparam int W   = 32;
    localparam int C   = 8;
    localparam int NCH = W / C;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] s;
    logic         zero;
    logic         ones;
    logic         busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_logic_unit #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .zero      (zero),
        .ones      (ones),
        .busy      (busy)
    );

    function automatic logic [W-1:0] model(input logic [2:0] o,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return ~(x | y);
            3'd3:    return x ^ y;
            3'd4:    return ~(x & y);
            3'd5:    return ~(x ^ y);
            3'd6:    return x & ~y;
            default: return x;
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept one op, scramble inputs while busy, check result,
    // hold backpressure for 'hold' cycles, then retire.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [W-1:0] x, input logic [W-1:0] y,
                          input int hold);
        logic [W-1:0] exp;
        logic [W-1:0] snap;
        int n;
        exp = model(o, x, y);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_acc"}, W'(busy), W'(1));
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            op = 3'($urandom); a = $urandom; b = $urandom;
            in_valid = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, W'(n), W'(NCH));
        check({tag, "_s"}, s, exp);
        check({tag, "_zero"}, W'(zero), W'(exp == '0));
        check({tag, "_ones"}, W'(ones), W'(exp == '1));
        snap = s;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_v"}, W'({out_valid, in_ready}), W'(2'b10));
            check({tag, "_hold_s"}, s, snap);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_ret"}, W'({out_valid, in_ready, busy}), W'(3'b010));
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        int t[$];
        int c;
        #12;
        check("rst_ready", W'({in_ready, busy, out_valid}), W'(3'b100));
        check("rst_s", s, '0);
        check("rst_flags", W'({zero, ones}), W'(0));
        rst_n = 1'b1;

        run_op("and", 3'd0, 32'd19999, 32'd112345, 0);
        check("and_const", s, 32'h0000_0619);
        run_op("or", 3'd1, 32'd19999, 32'd112345, 0);
        check("or_const", s, 32'h0001_FEDF);
        run_op("nor", 3'd2, 32'd19999, 32'd112345, 0);
        check("nor_const", s, 32'hFFFE_0120);
        run_op("xor0", 3'd3, 32'd15, 32'd15, 0);
        check("xor0_zero", W'(zero), W'(1));
        run_op("nand1", 3'd4, 32'd0, 32'd0, 0);
        check("nand1_ones", W'(ones), W'(1));
        run_op("andn", 3'd6, 32'd11, 32'd10, 0);
        check("andn_const", s, 32'd1);
        run_op("bp", 3'd5, 32'hDEAD_BEEF, 32'h1234_5678, 10);

        // reset while chunk 2 is being evaluated
        @(negedge clk);
        op = 3'd1; a = 32'hFFFF_FFFF; b = '0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_ctl", W'({in_ready, busy, out_valid}), W'(3'b100));
        check("mid_rst_s", s, '0);
        check("mid_rst_flags", W'({zero, ones}), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 3'd7, 32'hCAFE_F00D, 32'h0, 0);

        for (int i = 0; i < 24; i++) begin
            run_op("rnd", 3'($urandom), $urandom, $urandom,
                   int'($urandom_range(0, 3)));
        end

        // streaming throughput with out_ready held
        @(negedge clk);
        op = 3'd3; a = 32'h0F0F_AAAA; b = 32'hFF00_5555;
        in_valid = 1'b1; out_ready = 1'b1;
        c = 0;
        while (t.size() < 3 && c < 60) begin
            @(posedge clk); #1;
            c++;
            if (out_valid) begin
                t.push_back(c);
                check("tp_s", s, model(3'd3, 32'h0F0F_AAAA, 32'hFF00_5555));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("tp_count", W'(t.size()), W'(3));
        if (t.size() == 3) begin
            check("tp_gap1", W'(t[1] - t[0]), W'(NCH + 2));
            check("tp_gap2", W'(t[2] - t[1]), W'(NCH + 2));
        end
        repeat (NCH + 3) @(posedge clk);
        #1;
        check("tp_drain", W'({in_ready, busy}), W'(2'b10));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
